// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared state encoding for the run-time clock divider controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_OFF  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_STOP = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_OFF  = ST_OFF,
        S_RUN  = ST_RUN,
        S_STOP = ST_STOP
    } clkdiv_state_t;

endpackage
`default_nettype wire

// File: rtl/clkdiv_core.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_core
// Description : Half-period counter and toggle flop producing the divided clock.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic             clk_div,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             clk_div_q, clk_div_d;
    logic             w_last;

    assign w_last = (count_q == (div - C_ONE));

    // load is a synchronous clear so the next run always starts at the low phase
    always_comb begin
        count_d   = count_q;
        clk_div_d = clk_div_q;
        if (load) begin
            count_d   = '0;
            clk_div_d = 1'b0;
        end else if (run) begin
            if (w_last) begin
                count_d   = '0;
                clk_div_d = ~clk_div_q;
            end else begin
                count_d = count_q + C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q   <= '0;
            clk_div_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div  = clk_div_q;
    assign boundary = run && !load && w_last && clk_div_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_ctrl
// Description : Enable/stop sequencing and glitch-free ratio updates for clkdiv_core.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_div,
    output logic             period_tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             cfg_err,
    output logic             busy
);

    clkdiv_state_t    state_q, state_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             period_tick_q, period_tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic             w_active;
    logic             w_xfer;
    logic             w_zero;
    logic             w_boundary;

    assign w_active = (state_q != S_OFF);
    assign w_xfer   = cfg_valid && !pend_vld_q;
    assign w_zero   = (cfg_div == '0);

    clkdiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .run      (w_active),
        .load     (!w_active),
        .div      (cur_div_q),
        .clk_div  (clk_div),
        .boundary (w_boundary)
    );

    always_comb begin
        state_d       = state_q;
        cur_div_d     = cur_div_q;
        pend_div_d    = pend_div_q;
        pend_vld_d    = pend_vld_q;
        period_tick_d = w_boundary;
        cfg_err_d     = w_xfer && w_zero;

        case (state_q)
            S_OFF:   if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_STOP;
            S_STOP: begin
                if (en)              state_d = S_RUN;
                else if (w_boundary) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        // While stopped nothing is toggling, so a new ratio can apply at once
        if (w_xfer && !w_zero) begin
            if (!w_active) begin
                cur_div_d = cfg_div;
            end else begin
                pend_div_d = cfg_div;
                pend_vld_d = 1'b1;
            end
        end

        if (w_boundary && pend_vld_q) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_OFF;
            cur_div_q     <= WIDTH'(DEF_DIV);
            pend_div_q    <= '0;
            pend_vld_q    <= 1'b0;
            period_tick_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_div_q     <= cur_div_d;
            pend_div_q    <= pend_div_d;
            pend_vld_q    <= pend_vld_d;
            period_tick_q <= period_tick_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign cfg_ready   = !pend_vld_q;
    assign cur_div     = cur_div_q;
    assign period_tick = period_tick_q;
    assign cfg_err     = cfg_err_q;
    assign busy        = w_active || pend_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_ctrl
// Description : Directed self-checking bench for clkdiv_ctrl (WIDTH=4, DEF_DIV=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready;
    logic       clk_div;
    logic       period_tick;
    logic [3:0] cur_div;
    logic       cfg_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    clkdiv_ctrl #(
        .WIDTH   (4),
        .DEF_DIV (3)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .clk_div     (clk_div),
        .period_tick (period_tick),
        .cur_div     (cur_div),
        .cfg_err     (cfg_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_cycles(input logic exp, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {31'd0, clk_div}, {31'd0, exp});
            chk({tag, "_tick"}, {31'd0, period_tick}, 32'd0);
        end
    endtask

    task automatic wait_tick(input int max_cycles, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (period_tick !== 1'b1 && n < max_cycles);
        chk(tag, {31'd0, period_tick}, 32'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 4'd0;
        #12;
        chk("rst_clk_div", {31'd0, clk_div}, 32'd0);
        chk("rst_tick", {31'd0, period_tick}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_cur_div", {28'd0, cur_div}, 32'd3);

        // Start with N=3: rise 4 edges after en is sampled, period 6
        @(negedge clk);
        rstn = 1'b1;
        en   = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("start_clk", {31'd0, clk_div}, {31'd0, (((k - 1) / 3) % 2) == 1});
            chk("start_tick", {31'd0, period_tick}, {31'd0, (k >= 7) && (((k - 7) % 6) == 0)});
        end
        chk("start_busy", {31'd0, busy}, 32'd1);

        // Ratio 3 -> 5 offered in high phase; held valid while not ready is ignored
        step();
        step();
        step();
        chk("chg_high", {31'd0, clk_div}, 32'd1);
        cfg_valid = 1'b1;
        cfg_div   = 4'd5;
        step();
        chk("chg_ready0", {31'd0, cfg_ready}, 32'd0);
        cfg_div = 4'd9;
        step();
        chk("chg_ready0b", {31'd0, cfg_ready}, 32'd0);
        chk("chg_cur_old", {28'd0, cur_div}, 32'd3);
        cfg_valid = 1'b0;
        step();
        chk("chg_fall", {31'd0, clk_div}, 32'd0);
        chk("chg_tick", {31'd0, period_tick}, 32'd1);
        chk("chg_cur_new", {28'd0, cur_div}, 32'd5);
        chk("chg_ready1", {31'd0, cfg_ready}, 32'd1);
        chk_cycles(1'b0, 4, "n5_low");
        chk_cycles(1'b1, 5, "n5_high");
        step();
        chk("n5_tick", {31'd0, period_tick}, 32'd1);

        // Zero ratio: error pulse only
        cfg_valid = 1'b1;
        cfg_div   = 4'd0;
        step();
        chk("zero_err", {31'd0, cfg_err}, 32'd1);
        chk("zero_ready", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b0;
        step();
        chk("zero_err_off", {31'd0, cfg_err}, 32'd0);
        chk("zero_cur", {28'd0, cur_div}, 32'd5);
        chk_cycles(1'b0, 2, "zero_low");
        chk_cycles(1'b1, 5, "zero_high");
        step();
        chk("zero_tick", {31'd0, period_tick}, 32'd1);

        // Move to N=4, then stop one cycle after a rise
        cfg_valid = 1'b1;
        cfg_div   = 4'd4;
        step();
        cfg_valid = 1'b0;
        chk("n4_ready0", {31'd0, cfg_ready}, 32'd0);
        wait_tick(40, "n4_tick_wait");
        chk("n4_cur", {28'd0, cur_div}, 32'd4);
        chk_cycles(1'b0, 3, "n4_low");
        step();
        chk("n4_rise", {31'd0, clk_div}, 32'd1);
        en = 1'b0;
        step();
        chk("stop_busy", {31'd0, busy}, 32'd1);
        chk("stop_high1", {31'd0, clk_div}, 32'd1);
        step();
        chk("stop_high2", {31'd0, clk_div}, 32'd1);
        step();
        chk("stop_high3", {31'd0, clk_div}, 32'd1);
        step();
        chk("stop_fall", {31'd0, clk_div}, 32'd0);
        chk("stop_tick", {31'd0, period_tick}, 32'd1);
        chk("stop_busy0", {31'd0, busy}, 32'd0);
        chk_cycles(1'b0, 3, "off_idle");
        chk("off_busy", {31'd0, busy}, 32'd0);

        // Stop and ratio transfer in the same RUN cycle
        en = 1'b1;
        step();
        chk("re_busy", {31'd0, busy}, 32'd1);
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 4'd2;
        step();
        cfg_valid = 1'b0;
        chk("sim_ready0", {31'd0, cfg_ready}, 32'd0);
        chk("sim_busy", {31'd0, busy}, 32'd1);
        chk_cycles(1'b0, 2, "sim_low");
        chk_cycles(1'b1, 4, "sim_high");
        step();
        chk("sim_tick", {31'd0, period_tick}, 32'd1);
        chk("sim_cur", {28'd0, cur_div}, 32'd2);
        chk("sim_busy0", {31'd0, busy}, 32'd0);
        chk("sim_clk0", {31'd0, clk_div}, 32'd0);
        step();
        chk("sim_off", {31'd0, clk_div}, 32'd0);

        // Re-enable at N=2: period 4
        en = 1'b1;
        step();
        chk("n2_start", {31'd0, clk_div}, 32'd0);
        chk_cycles(1'b0, 1, "n2_low_a");
        chk_cycles(1'b1, 2, "n2_high_a");
        step();
        chk("n2_tick_a", {31'd0, period_tick}, 32'd1);
        chk_cycles(1'b0, 1, "n2_low_b");
        chk_cycles(1'b1, 2, "n2_high_b");
        step();
        chk("n2_tick_b", {31'd0, period_tick}, 32'd1);

        // Async reset during high phase with a ratio pending
        step();
        step();
        chk("rst2_high", {31'd0, clk_div}, 32'd1);
        cfg_valid = 1'b1;
        cfg_div   = 4'd7;
        step();
        cfg_valid = 1'b0;
        chk("rst2_pend", {31'd0, cfg_ready}, 32'd0);
        chk("rst2_high2", {31'd0, clk_div}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rst2_clk0", {31'd0, clk_div}, 32'd0);
        chk("rst2_cur", {28'd0, cur_div}, 32'd3);
        chk("rst2_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("rst2_after_cur", {28'd0, cur_div}, 32'd3);
        chk("rst2_after_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst2_after_busy", {31'd0, busy}, 32'd0);

        // N=1 loaded in OFF: toggles every cycle
        cfg_valid = 1'b1;
        cfg_div   = 4'd1;
        step();
        cfg_valid = 1'b0;
        chk("n1_cur", {28'd0, cur_div}, 32'd1);
        chk("n1_ready", {31'd0, cfg_ready}, 32'd1);
        en = 1'b1;
        step();
        chk("n1_start", {31'd0, clk_div}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("n1_clk", {31'd0, clk_div}, {31'd0, (k % 2) == 1});
            chk("n1_tick", {31'd0, period_tick}, {31'd0, (k % 2) == 0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Run-time controller for the mod-N clock divider: owns the half-period counter and the divided output, and sequences enable, disable and divide-ratio changes so that `clk_div` never produces a runt pulse. New ratios arrive over a valid/ready handshake and take effect only at a period boundary, the falling edge of `clk_div`. The block sits between the configuration register interface and every consumer of the divided clock/strobe.

## Interface
- `WIDTH`, default 4: width of the ratio and counter.
- `DEF_DIV`, default 3: half-period ratio loaded at reset. Must be in the range 1..2^WIDTH-1.
- `clk` (input, 1): single clock; all logic on its rising edge.
- `rstn` (input, 1): reset, asynchronous, active-low.
- `en` (input, 1): level. 1 requests running; 0 requests a clean stop.
- `cfg_valid` (input, 1): new ratio offered.
- `cfg_div` (input, WIDTH): new half-period ratio N. Output period is 2·N `clk` cycles.
- `cfg_ready` (output, 1): ratio can be accepted.
- `clk_div` (output, 1): divided output, registered, 50% duty.
- `period_tick` (output, 1): one-cycle pulse registered with each `clk_div` 1→0 transition.
- `cur_div` (output, WIDTH): ratio currently in effect.
- `cfg_err` (output, 1): one-cycle pulse, the cycle after a transfer with `cfg_div`==0.
- `busy` (output, 1): 1 when the state is not OFF, or when `pend_vld`==1.

## Operation
- **States:** OFF, RUN, STOP. Internal registers:
  - `count` (WIDTH bits)
  - `pend_div` (WIDTH bits)
  - `pend_vld` (1 bit)
- **Transfer rule:** a transfer occurs when `cfg_valid && cfg_ready`.
  - `cfg_ready` = !`pend_vld`, decoded from registers.
  - `cfg_valid` may be held; it has no effect while `cfg_ready`=0.
- **Zero ratio:** a transfer with `cfg_div`==0 is consumed and pulses `cfg_err`. It changes nothing else.
- **OFF state:**
  - `clk_div`=0, `count`=0.
  - A nonzero transfer loads `cur_div` directly on the next cycle.
  - `en`=1 moves to RUN next cycle with `count`=0 and `clk_div`=0.
- **RUN state:**
  - If `count`==`cur_div`-1: `count`←0 and `clk_div` toggles.
  - Otherwise `count`←`count`+1.
- **Boundary:** the cycle in RUN or STOP where `count`==`cur_div`-1 and `clk_div`==1.
- **Change in flight (RUN or STOP):**
  - A nonzero transfer captures `pend_div` and sets `pend_vld`.
  - At the next boundary: `cur_div`←`pend_div`, `pend_vld`←0.
  - Counting restarts from 0 under the new ratio. The low half already uses the new N.
- **Stop request:** `en`=0 in RUN moves to STOP. STOP counts and toggles exactly like RUN.
- **Stop completion:** at the boundary in STOP, `clk_div`←0, `count`←0, apply any pending ratio, and go to OFF.
- **Re-enable during STOP:** `en`=1 in STOP returns to RUN on the next cycle with no output disturbance.
- **Simultaneous events:** `en` falling and a transfer in the same RUN cycle are both honoured. The pending ratio is applied when the block enters OFF.

## Timing
- **Reset values:**
  - Outputs: `clk_div`=0, `period_tick`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=1, `cur_div`=DEF_DIV.
  - Internal: `count`=0, `pend_vld`=0, state OFF.
- **Reset mid-operation:** drops any pending ratio. Outputs go to the reset values immediately (asynchronous).
- **Start latency:** with `en` sampled 1 in OFF at cycle t, RUN begins at t+1. The first `clk_div` rise is at t+1+N.
- **Steady state:** high for N cycles, then low for N cycles.
- **N=1:** `clk_div` toggles every cycle (period 2).
- **Ratio change:** takes effect at the first boundary after the transfer cycle. The worst case is 2·N_old cycles.
- **Stop latency:** `clk_div` never returns to 0 other than at a boundary.
  - If `clk_div`=0 when `en` falls, a full high phase still completes.
  - The final high phase is always N_old cycles long.
- **`period_tick`:** asserted in the same cycle `clk_div` becomes 0 at a boundary, including the final stop boundary.

## Structure
- **Package `clkdiv_pkg`:**
  - State enum `clkdiv_state_t` (OFF/RUN/STOP).
  - Localparams for state encoding.
- **Sub-module `clkdiv_core`:**
  - Holds the counter and toggle flop.
  - Inputs: `run`, `div`, `load`.
  - Outputs: `clk_div`, `boundary`.
- **`clkdiv_ctrl`:** holds the FSM, the handshake, the pending register and the status outputs.

## Test plan
- Reset, `en`=1 with DEF_DIV=3 → `clk_div` rises 4 cycles after `en` is sampled, then period 6. `period_tick` pulses every 6 cycles.
- While running N=3, transfer `cfg_div`=5 during the high phase → `cfg_ready`=0 until the boundary. Then low 5, high 5, and `cur_div`=5.
- Transfer `cfg_div`=0 in RUN → `cfg_err` pulses one cycle. `cur_div` and the period are unchanged.
- `en`→0 one cycle after a `clk_div` rise (N=4) → high completes (4 cycles total). `clk_div` stays 0, state OFF, `busy`=0.
- `en`→0 and `cfg_div`=2 transfer in the same cycle → clean stop, then `cur_div`=2 in OFF. Re-enable → period 4.
- Assert `rstn`=0 mid high phase with a ratio pending → `clk_div`=0 asynchronously. After release: `cur_div`=3, `pend_vld`=0, `cfg_ready`=1.
